// File: rtl/hw_port_seq_pkg.sv
// Shared constants for the PIO command sequencer: FSM state codes,
// to_hw/from_hw word field positions and the default clear opcode.
package hw_port_seq_pkg;

  localparam logic [2:0] ST_PRIME = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // to_hw_word fields
  localparam int TOG_BIT = 15;
  localparam int OP_HI   = 14;
  localparam int OP_LO   = 12;
  localparam int ARG_HI  = 11;
  localparam int ARG_LO  = 0;

  // from_hw_word status bits (result shares ARG_HI:ARG_LO)
  localparam int ST_ACK  = 15;
  localparam int ST_BUSY = 14;
  localparam int ST_OVR  = 13;
  localparam int ST_ERR  = 12;

  localparam logic [2:0] CLR_OPCODE_DEF = 3'd7;

endpackage

// File: rtl/hw_port_toggle_detect.sv
// Request-toggle edge detector. prev_tog follows the toggle every cycle;
// the edge is masked while the parent is priming so the toggle level
// present at reset release is absorbed rather than treated as a request.
module hw_port_toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic prime,
  input  logic tog,
  output logic tog_edge
);

  logic prev_tog;

  // track last toggle level
  always_ff @(posedge clk) begin
    if (reset) prev_tog <= 1'b0;
    else       prev_tog <= tog;
  end

  assign tog_edge = ~prime & (tog ^ prev_tog);

endmodule

// File: rtl/hw_port_cmd_sequencer.sv
// Turns toggle-handshake commands on the to_hw PIO word into a valid/ready
// command stream and reports completion on the from_hw PIO word.
// Optional macro HW_PORT_SEQ_TIMEOUT_EN adds an engine-response timeout.
module hw_port_cmd_sequencer
  import hw_port_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TMO_W          = 20,
  parameter logic [2:0]  CLR_OPCODE     = CLR_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] to_hw_word,
  output logic [15:0] from_hw_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_opcode,
  output logic [11:0] cmd_arg,
  input  logic        done_valid,
  input  logic        done_err,
  input  logic [11:0] done_result,
  output logic        busy
);

  logic        in_tog;
  logic [2:0]  in_op;
  logic [11:0] in_arg;
  logic        tog_edge;
  logic [2:0]  state;
  logic        ack_tog, cap_tog;
  logic        ovr_w;            // live sticky overrun, published on RESP
  logic        st_ovr, st_err;
  logic [11:0] st_res;
  logic        pend_vld, pend_tog;
  logic [2:0]  pend_op;
  logic [11:0] pend_arg;
  logic        tmo_hit;
  logic        engaged;

  assign in_tog  = to_hw_word[TOG_BIT];
  assign in_op   = to_hw_word[OP_HI:OP_LO];
  assign in_arg  = to_hw_word[ARG_HI:ARG_LO];
  assign engaged = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_RESP);

  hw_port_toggle_detect u_tdet (
    .clk      (clk),
    .reset    (reset),
    .prime    (state == ST_PRIME),
    .tog      (in_tog),
    .tog_edge (tog_edge)
  );

`ifdef HW_PORT_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // cycles spent waiting on the engine; zero on every ISSUE entry
  always_ff @(posedge clk) begin
    if (reset)                                       tmo_cnt <= '0;
    else if (state != ST_ISSUE && state != ST_WAIT)  tmo_cnt <= '0;
    else                                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  // >= so a handshake landing on the last ISSUE cycle still times out in WAIT
  assign tmo_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                   (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [TMO_W-1:0] tmo_unused;
  assign tmo_unused = TMO_W'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  // main sequencer: pending slot, command capture and status updates
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_PRIME;
      ack_tog    <= 1'b0;
      cap_tog    <= 1'b0;
      ovr_w      <= 1'b0;
      st_ovr     <= 1'b0;
      st_err     <= 1'b0;
      st_res     <= '0;
      pend_vld   <= 1'b0;
      pend_tog   <= 1'b0;
      pend_op    <= '0;
      pend_arg   <= '0;
      cmd_opcode <= '0;
      cmd_arg    <= '0;
    end else begin
      // requests arriving while engaged go to the one-deep slot or are dropped
      if (tog_edge && engaged) begin
        if (!pend_vld) begin
          pend_vld <= 1'b1;
          pend_tog <= in_tog;
          pend_op  <= in_op;
          pend_arg <= in_arg;
        end else begin
          ovr_w <= 1'b1;
        end
      end

      case (state)
        ST_PRIME: begin
          ack_tog <= in_tog;
          state   <= ST_IDLE;
        end
        ST_IDLE: if (tog_edge) begin
          cap_tog <= in_tog;
          if (in_op == CLR_OPCODE) begin
            ovr_w  <= 1'b0;
            st_err <= 1'b0;
            st_res <= '0;
            state  <= ST_RESP;
          end else begin
            cmd_opcode <= in_op;
            cmd_arg    <= in_arg;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) state <= ST_WAIT;
          else if (tmo_hit) begin
            st_err <= 1'b1;
            st_res <= 12'hFFF;
            state  <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (done_valid) begin
            st_err <= done_err;
            st_res <= done_result;
            state  <= ST_RESP;
          end else if (tmo_hit) begin
            st_err <= 1'b1;
            st_res <= 12'hFFF;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_tog <= cap_tog;
          st_ovr  <= ovr_w;
          if (pend_vld) begin
            pend_vld <= 1'b0;
            cap_tog  <= pend_tog;
            if (pend_op == CLR_OPCODE) begin
              ovr_w  <= 1'b0;
              st_err <= 1'b0;
              st_res <= '0;
              state  <= ST_RESP;
            end else begin
              cmd_opcode <= pend_op;
              cmd_arg    <= pend_arg;
              state      <= ST_ISSUE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = (state == ST_ISSUE);
  assign busy      = engaged | pend_vld;

  // status word: busy is live, the rest are registered
  always_comb begin
    from_hw_word                 = '0;
    from_hw_word[ST_ACK]         = ack_tog;
    from_hw_word[ST_BUSY]        = busy;
    from_hw_word[ST_OVR]         = st_ovr;
    from_hw_word[ST_ERR]         = st_err;
    from_hw_word[ARG_HI:ARG_LO]  = st_res;
  end

endmodule

// File: tb/tb_hw_port_cmd_sequencer.sv
// Self-checking bench for hw_port_cmd_sequencer: directed corner cases,
// a vector table and a randomized run against a transaction-level model.
// The timeout scenario runs only when HW_PORT_SEQ_TIMEOUT_EN is defined.
module tb_hw_port_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] to_hw_word;
  logic [15:0] from_hw_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [11:0] cmd_arg;
  logic        done_valid;
  logic        done_err;
  logic [11:0] done_result;
  logic        busy;

  hw_port_cmd_sequencer #(.TIMEOUT_CYCLES(16), .TMO_W(20), .CLR_OPCODE(3'd7)) dut (
    .clk(clk), .reset(reset), .to_hw_word(to_hw_word), .from_hw_word(from_hw_word),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg),
    .done_valid(done_valid), .done_err(done_err), .done_result(done_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic sw_tog;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] arg;
    int          rdy;
    int          dly;
    logic        err;
    logic [11:0] res;
    logic [14:0] exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic post(input logic [2:0] op, input logic [11:0] arg);
    sw_tog     = ~sw_tog;
    to_hw_word = {sw_tog, op, arg};
  endtask

  task automatic wait_ack(input logic tgt);
    int t = 0;
    while (from_hw_word[15] !== tgt && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ack_wait", from_hw_word[15], tgt);
  endtask

  // engine side: accept after rdy cycles, complete dly cycles later
  task automatic serve(input logic [2:0] op, input logic [11:0] arg, input int rdy,
                       input int dly, input logic err, input logic [11:0] res);
    int t = 0;
    int bad = 0;
    while (cmd_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_valid", cmd_valid, 1);
    chk("cmd_payload", {cmd_opcode, cmd_arg}, {op, arg});
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_opcode !== op || cmd_arg !== arg) bad++;
    end
    chk("cmd_stable", bad, 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("cmd_drop", cmd_valid, 0);
    for (int i = 0; i < dly; i++) @(negedge clk);
    done_valid = 1'b1; done_err = err; done_result = res;
    @(negedge clk);
    done_valid = 1'b0; done_err = 1'b0; done_result = '0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [11:0] arg, input int rdy,
                        input int dly, input logic err, input logic [11:0] res);
    post(op, arg);
    if (op != 3'd7) serve(op, arg, rdy, dly, err, res);
    wait_ack(sw_tog);
  endtask

  initial begin
    vec_t        vt[6];
    logic        tog_a, tog_b;
    int          bad;
    logic        m_ovr, m_err;
    logic [11:0] m_res;
    logic [2:0]  r_op;
    logic [11:0] r_arg, r_res;
    logic        r_err;

    vt[0] = '{3'd1, 12'h123, 0,  0, 1'b0, 12'h0AB, 15'h00AB};
    vt[1] = '{3'd2, 12'hFFF, 10, 2, 1'b1, 12'h555, 15'h1555};
    vt[2] = '{3'd7, 12'h000, 0,  0, 1'b0, 12'h000, 15'h0000};
    vt[3] = '{3'd0, 12'h000, 3,  5, 1'b0, 12'hFFF, 15'h0FFF};
    vt[4] = '{3'd6, 12'h800, 1,  0, 1'b1, 12'h000, 15'h1000};
    vt[5] = '{3'd7, 12'h5A5, 2,  2, 1'b1, 12'h777, 15'h0000};

    reset = 1'b1; to_hw_word = '0; cmd_ready = 1'b0;
    done_valid = 1'b0; done_err = 1'b0; done_result = '0; sw_tog = 1'b0;

    // reset state, then basic command with ready in the first valid cycle
    repeat (3) @(negedge clk);
    chk("rst_status", from_hw_word, 16'h0000);
    chk("rst_valid_busy", {cmd_valid, busy}, 2'b00);
    chk("rst_payload", {cmd_opcode, cmd_arg}, 15'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    post(3'd1, 12'h123);
    chk("t1_no_early", cmd_valid, 0);
    @(negedge clk);
    chk("t1_valid_edge1", {cmd_valid, cmd_opcode, cmd_arg}, {1'b1, 3'd1, 12'h123});
    serve(3'd1, 12'h123, 0, 0, 1'b0, 12'h0AB);
    wait_ack(1'b1);
    chk("t1_status", from_hw_word, 16'h80AB);
    chk("t1_busy", busy, 0);

    // toggle already high through reset must not fire a command
    reset = 1'b1; to_hw_word = 16'h8000; sw_tog = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) bad++;
    end
    chk("t2_no_cmd", bad, 0);
    chk("t2_ack_busy", {from_hw_word[15], busy}, 2'b10);

    // three posts while engaged: one pends, one overruns, then clear
    post(3'd3, 12'h0A1); tog_a = sw_tog;
    while (cmd_valid !== 1'b1) @(negedge clk);
    cmd_ready = 1'b1; @(negedge clk); cmd_ready = 1'b0;
    post(3'd4, 12'h0B2); tog_b = sw_tog;
    @(negedge clk);
    chk("t4_busy_wait", busy, 1);
    post(3'd5, 12'h0C3);
    @(negedge clk);
    done_valid = 1'b1; done_err = 1'b1; done_result = 12'h03A;
    @(negedge clk);
    done_valid = 1'b0; done_err = 1'b0; done_result = '0;
    wait_ack(tog_a);
    chk("t4_status_a", from_hw_word, {tog_a, 3'b111, 12'h03A});
    chk("t4_pend_issue", {cmd_valid, cmd_opcode, cmd_arg}, {1'b1, 3'd4, 12'h0B2});
    serve(3'd4, 12'h0B2, 0, 0, 1'b0, 12'h0B0);
    wait_ack(tog_b);
    chk("t4_status_b", from_hw_word, {tog_b, 3'b010, 12'h0B0});
    post(3'd7, 12'h000);
    @(negedge clk);
    chk("t4_clr_resp", {cmd_valid, busy}, 2'b01);
    @(negedge clk);
    chk("t4_clr_status", from_hw_word, {sw_tog, 15'h0000});

    // done_valid outside WAIT is ignored
    done_valid = 1'b1; done_err = 1'b1; done_result = 12'hBAD;
    @(negedge clk);
    done_valid = 1'b0; done_err = 1'b0; done_result = '0;
    repeat (2) @(negedge clk);
    chk("t6_idle_done", from_hw_word, {sw_tog, 15'h0000});
    post(3'd1, 12'h066);
    @(negedge clk);
    done_valid = 1'b1; done_err = 1'b1; done_result = 12'hBAD;
    @(negedge clk);
    done_valid = 1'b0; done_err = 1'b0; done_result = '0;
    serve(3'd1, 12'h066, 0, 1, 1'b0, 12'h111);
    wait_ack(sw_tog);
    chk("t6_issue_done", from_hw_word, {sw_tog, 3'b000, 12'h111});

    // vector table
    for (int i = 0; i < 6; i++) begin
      do_cmd(vt[i].op, vt[i].arg, vt[i].rdy, vt[i].dly, vt[i].err, vt[i].res);
      chk($sformatf("vec%0d_status", i), from_hw_word, {sw_tog, vt[i].exp_lo});
    end

    // randomized commands against a transaction-level model
    m_ovr = 1'b0; m_err = 1'b0; m_res = '0;
    for (int n = 0; n < 40; n++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_arg = 12'($urandom);
      r_err = 1'($urandom);
      r_res = 12'($urandom);
      do_cmd(r_op, r_arg, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), r_err, r_res);
      if (r_op == 3'd7) begin
        m_ovr = 1'b0; m_err = 1'b0; m_res = '0;
      end else begin
        m_err = r_err; m_res = r_res;
      end
      chk($sformatf("rand%0d_status", n), from_hw_word, {sw_tog, 1'b0, m_ovr, m_err, m_res});
    end

`ifdef HW_PORT_SEQ_TIMEOUT_EN
    // engine never answers: RESP 16 cycles after ISSUE entry
    post(3'd2, 12'h0EE);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1) bad++;
    end
    chk("tmo_valid_hold", bad, 0);
    @(negedge clk);
    chk("tmo_resp", {cmd_valid, busy}, 2'b01);
    @(negedge clk);
    chk("tmo_status", from_hw_word, {sw_tog, 3'b001, 12'hFFF});
    done_valid = 1'b1; done_result = 12'h123;
    @(negedge clk);
    done_valid = 1'b0; done_result = '0;
    @(negedge clk);
    chk("tmo_late_done", from_hw_word, {sw_tog, 3'b001, 12'hFFF});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
